// File: rtl/mips_cpu_bus_mem_ctrl_if.sv
// mips_cpu_bus_mem_ctrl_if: datapath request, Avalon bus and register-file write-back signals
interface mips_cpu_bus_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_dest;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        reg_write_en;
  logic [4:0]  reg_write_dest;
  logic [31:0] reg_write_data;
  logic [2:0]  load_type;
  logic [3:0]  instr_byteenable;
  logic        done;
  logic        err;
  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_dest, avm_waitrequest, avm_readdata,
    output req_ready, avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
           reg_write_en, reg_write_dest, reg_write_data, load_type, instr_byteenable, done, err
  );
  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_dest, avm_waitrequest, avm_readdata,
    input  req_ready, avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
           reg_write_en, reg_write_dest, reg_write_data, load_type, instr_byteenable, done, err
  );
endinterface

// File: rtl/mips_cpu_bus_mem_ctrl.sv
// mips_cpu_bus_mem_ctrl: multi-cycle load/store sequencer onto an Avalon-style bus.
// MIPS_MEM_CTRL_ALIGN_CHECK_EN turns misaligned word/halfword accesses into err completions.
module mips_cpu_bus_mem_ctrl #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd0
) (
  input logic clk,
  input logic reset,
  mips_cpu_bus_mem_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, READ, WRITE, WB, FIN} state_t;
  state_t      state_q;
  logic        req_ready_q, avm_read_q, avm_write_q, reg_write_en_q, done_q, err_q;
  logic [31:0] avm_address_q, avm_writedata_q, reg_write_data_q;
  logic [3:0]  avm_byteenable_q, instr_byteenable_q;
  logic [4:0]  reg_write_dest_q;
  logic [2:0]  load_type_q, lt_q;
  logic [15:0] wait_cnt_q;
  logic [3:0]  op, be_d;
  logic [1:0]  o;
  logic [2:0]  lt_d;
  logic [31:0] wdata_d;
  logic        is_load, is_store, word, half, bt, misalign, timeout;
  always_comb begin
    op       = bus.req_op;
    o        = bus.req_addr[1:0];
    is_load  = !op[3] && op != 4'd7;
    is_store = op == 4'd8 || op == 4'd9 || op == 4'd10;
    word     = op == 4'd0 || op == 4'd8;
    half     = op == 4'd3 || op == 4'd4 || op == 4'd10;
    bt       = op == 4'd1 || op == 4'd2 || op == 4'd9;
    // LWL keeps the high-order lanes from the offset down; LWR fills up from the top lane
    be_d     = word ? 4'hF : bt ? 4'b0001 << o : half ? (o[1] ? 4'hC : 4'h3) :
               op == 4'd5 ? 4'hF >> o : 4'hF << ~o;
    lt_d     = (op == 4'd6 && o == 2'd3) ? 3'd0 : op[2:0];
    wdata_d  = bt ? {4{bus.req_wdata[7:0]}} : half ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
`ifdef MIPS_MEM_CTRL_ALIGN_CHECK_EN
    misalign = (word && o != 2'd0) || (half && o[0]);
`else
    misalign = 1'b0;
`endif
    timeout  = TIMEOUT_CYCLES != 16'd0 && wait_cnt_q == TIMEOUT_CYCLES - 16'd1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= IDLE;
      req_ready_q        <= 1'b1;
      avm_read_q         <= 1'b0;
      avm_write_q        <= 1'b0;
      reg_write_en_q     <= 1'b0;
      done_q             <= 1'b0;
      err_q              <= 1'b0;
      avm_address_q      <= '0;
      avm_writedata_q    <= '0;
      reg_write_data_q   <= '0;
      avm_byteenable_q   <= '0;
      instr_byteenable_q <= '0;
      reg_write_dest_q   <= '0;
      load_type_q        <= '0;
      lt_q               <= '0;
      wait_cnt_q         <= '0;
    end else begin
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      reg_write_en_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.req_valid) begin
          req_ready_q      <= 1'b0;
          wait_cnt_q       <= '0;
          lt_q             <= lt_d;
          reg_write_dest_q <= bus.req_dest;
          avm_address_q    <= {bus.req_addr[31:2], 2'b00};
          avm_writedata_q  <= wdata_d;
          if ((!is_load && !is_store) || misalign) begin
            state_q <= FIN;
            done_q  <= 1'b1;
            err_q   <= misalign;
          end else begin
            state_q          <= is_load ? READ : WRITE;
            avm_read_q       <= is_load;
            avm_write_q      <= is_store;
            avm_byteenable_q <= be_d;
          end
        end
        READ, WRITE: if (!bus.avm_waitrequest || timeout) begin
          avm_read_q       <= 1'b0;
          avm_write_q      <= 1'b0;
          avm_byteenable_q <= '0;
          done_q           <= 1'b1;
          err_q            <= bus.avm_waitrequest;
          if (state_q == READ && !bus.avm_waitrequest) begin
            state_q            <= WB;
            reg_write_data_q   <= bus.avm_readdata;
            reg_write_en_q     <= reg_write_dest_q != 5'd0;
            load_type_q        <= lt_q;
            instr_byteenable_q <= avm_byteenable_q;
          end else
            state_q <= FIN;
        end else
          wait_cnt_q <= wait_cnt_q + 16'd1;
        default: begin
          state_q            <= IDLE;
          req_ready_q        <= 1'b1;
          load_type_q        <= '0;
          instr_byteenable_q <= '0;
        end
      endcase
    end
  end
  assign bus.req_ready        = req_ready_q;
  assign bus.avm_address      = avm_address_q;
  assign bus.avm_read         = avm_read_q;
  assign bus.avm_write        = avm_write_q;
  assign bus.avm_writedata    = avm_writedata_q;
  assign bus.avm_byteenable   = avm_byteenable_q;
  assign bus.reg_write_en     = reg_write_en_q;
  assign bus.reg_write_dest   = reg_write_dest_q;
  assign bus.reg_write_data   = reg_write_data_q;
  assign bus.load_type        = load_type_q;
  assign bus.instr_byteenable = instr_byteenable_q;
  assign bus.done             = done_q;
  assign bus.err              = err_q;
endmodule

// File: doc/mips_cpu_bus_mem_ctrl.md
Name: mips_cpu_bus_mem_ctrl

Overview:
Multi-cycle load/store sequencer between the CPU datapath and the Avalon-style memory bus. It accepts one load/store request, derives the bus byteenable from the op and the address offset, and runs the bus read/write while honouring waitrequest. For loads, it then drives the register-file write port (reg_write_en, reg_write_dest, reg_write_data, load_type, instr_byteenable) for exactly one cycle.

Parameters:
TIMEOUT_CYCLES, 0, max consecutive waitrequest cycles before abort; 0 = watchdog disabled; 16-bit counter.

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
req_valid  in  1  datapath request strobe
req_ready  out  1  high only in IDLE; accept = req_valid & req_ready
req_op  in  4  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR, 8 SW, 9 SB, 10 SH; others invalid
req_addr  in  32  byte address
req_wdata  in  32  store data (rt)
req_dest  in  5  load destination register
avm_address  out  32  {req_addr[31:2],2'b00}
avm_read  out  1  bus read
avm_write  out  1  bus write
avm_writedata  out  32  lane-aligned store data
avm_byteenable  out  4  active lanes
avm_waitrequest  in  1  bus stall
avm_readdata  in  32  read data, valid when avm_read & !avm_waitrequest
reg_write_en  out  1  register-file write strobe, 1 cycle
reg_write_dest  out  5  = latched req_dest
reg_write_data  out  32  raw captured readdata
load_type  out  3  0 word, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR
instr_byteenable  out  4  lane code for register-file merge
done  out  1  1-cycle completion pulse
err  out  1  valid with done; misalign (optional feature) or timeout

Behaviour:
- Reset values: all outputs 0 except req_ready=1; state IDLE. Reset in any state returns the block to IDLE on that edge, with no write-back and bus strobes low the next cycle.
- FSM states: IDLE, READ, WRITE, WB, FIN.
  - IDLE: on accept, latch op/addr/wdata/dest and compute byteenable. Load → READ; store → WRITE; invalid op → FIN with err=0 and no bus cycle.
  - READ: avm_read=1. Address, byteenable and read strobe are held stable while waitrequest=1. On !waitrequest, capture readdata → WB.
  - WB: reg_write_en=1, done=1 (err=0) → IDLE.
  - WRITE: avm_write=1, held stable. On !waitrequest → FIN.
  - FIN: done=1 for one cycle → IDLE.
- Latency with no wait: accept at cycle N; bus strobe at N+1; done/reg_write_en at N+2. Each wait cycle adds 1.
- Byteenable, with o = req_addr[1:0]:
  - LW/SW: 1111.
  - LB/LBU/SB: 0001<<o.
  - LH/LHU/SH: 0011 if o[1]=0, else 1100.
  - LWL: o=0→1111, 1→0111, 2→0011, 3→0001.
  - LWR: o=0→1000, 1→1100, 2→1110, 3→1111, and o=3 is issued with load_type=0.
- Store data:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- Bus reads use the same byteenable as instr_byteenable.
- Without the optional feature, misaligned LW/SW/LH/LHU/SH ignore the offending low bits: LW/SW as o=0, halfword ops as o&2.
- Watchdog: if TIMEOUT_CYCLES≠0 and waitrequest stays high TIMEOUT_CYCLES consecutive cycles in READ/WRITE, drop strobes → FIN with err=1. No write-back occurs.
- reg_write_en is never asserted when req_dest=0; done still pulses.
- req_valid outside IDLE is ignored. No queuing.

Optional Feature:
MIPS_MEM_CTRL_ALIGN_CHECK_EN.
- Defined: misaligned LW/SW (o≠0) or LH/LHU/SH (o[0]=1) go IDLE→FIN with err=1. No bus strobe, no write-back.
- Undefined: the alignment-ignore rule above applies, and err is driven only by the watchdog.

Test Plan:
- LW addr 0x1004, waitrequest=0, readdata 0xDEADBEEF → avm_read at N+1, addr 0x1004, be 1111; at N+2 reg_write_en=1, data 0xDEADBEEF, load_type 0, done=1.
- LB addr 0x2003, req_dest 5, readdata 0x80000000, waitrequest high 3 cycles → be 1000 stable for 4 cycles; reg_write_en at N+5, dest 5, load_type 1, instr_byteenable 1000.
- SH addr 0x3002, wdata 0x0000ABCD → avm_write, be 1100, writedata 0xABCDABCD; done at N+2; reg_write_en stays 0.
- LWR addr 0x4003 → be 1111, load_type 0. LWL addr 0x4001 → be 0111, load_type 5.
- TIMEOUT_CYCLES=8, waitrequest stuck high → avm_read drops after 8 cycles; done=1, err=1, no reg_write_en. Separately, reset asserted in READ → IDLE next cycle, req_ready=1, no write-back.
- With MIPS_MEM_CTRL_ALIGN_CHECK_EN, LW addr 0x5002 → no bus strobe; done=1, err=1 at N+1. Without the macro, the same request reads 0x5000 with be 1111.
